// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_BITS LSB-first, optional parity,
// 1 or 2 stop bits. Baud divider is derived from CLK_FREQ_HZ and BAUD_RATE.
//
// Ports:
//   clk      - system clock, all logic on posedge
//   rst      - asynchronous active-high reset
//   tx_data  - word to send, sampled only when accepted
//   tx_valid - producer has a word
//   tx_ready - block can accept (high only when idle)
//   tx_busy  - frame in progress (inverse of tx_ready)
//   tx_done  - one-cycle pulse after the final stop bit completes
//   tx       - serial line, idles high
module uart_tx_param #(
   parameter int CLK_FREQ_HZ = 20_000_000,
   parameter int BAUD_RATE   = 9600,
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_busy,
   output logic                 tx_done,
   output logic                 tx
);

   localparam int CLKS_PER_BIT =
      (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
   localparam int BW =
      (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int CW = 4;

   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_div
      $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_tx_param: DATA_BITS must be 5..9");
   end
   if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_par
      $error("uart_tx_param: PARITY_MODE must be 0..2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               state_q, state_n;
   logic [BW-1:0]        baud_q, baud_n;
   logic [CW-1:0]        bit_q, bit_n;
   logic [DATA_BITS-1:0] shift_q, shift_n;
   logic                 par_q, par_n;
   logic                 done_q, done_n;

   logic bit_end;
   logic par_calc;

   assign bit_end  = (baud_q == BAUD_LAST);
   assign par_calc = ^tx_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         baud_q  <= baud_n;
         bit_q   <= bit_n;
         shift_q <= shift_n;
         par_q   <= par_n;
         done_q  <= done_n;
      end
   end

   always_comb begin
      state_n = state_q;
      baud_n  = baud_q;
      bit_n   = bit_q;
      shift_n = shift_q;
      par_n   = par_q;
      done_n  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            baud_n = '0;
            bit_n  = '0;
            if (tx_valid) begin
               state_n = S_START;
               shift_n = tx_data;
               par_n   = (PARITY_MODE == 2) ? ~par_calc : par_calc;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_n = S_DATA;
               baud_n  = '0;
               bit_n   = '0;
            end else begin
               baud_n = baud_q + 1'b1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               baud_n  = '0;
               shift_n = shift_q >> 1;
               if (bit_q == DATA_LAST) begin
                  bit_n   = '0;
                  state_n = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_n = bit_q + 1'b1;
               end
            end else begin
               baud_n = baud_q + 1'b1;
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_n = S_STOP;
               baud_n  = '0;
               bit_n   = '0;
            end else begin
               baud_n = baud_q + 1'b1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               baud_n = '0;
               if (bit_q == STOP_LAST) begin
                  bit_n   = '0;
                  state_n = S_IDLE;
                  done_n  = 1'b1;
               end else begin
                  bit_n = bit_q + 1'b1;
               end
            end else begin
               baud_n = baud_q + 1'b1;
            end
         end
         default: begin
            state_n = S_IDLE;
            baud_n  = '0;
            bit_n   = '0;
         end
      endcase
   end

   // Line level decoded from registered state, so an async reset
   // forces it high at once.
   always_comb begin
      tx = 1'b1;
      unique case (state_q)
         S_START:  tx = 1'b0;
         S_DATA:   tx = shift_q[0];
         S_PARITY: tx = par_q;
         default:  tx = 1'b1;
      endcase
   end

   assign tx_ready = (state_q == S_IDLE);
   assign tx_busy  = ~tx_ready;
   assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: several parameter sets driven from a frame table
// plus hand sequences for back-to-back, reset mid-frame and ignored input.
module tb_uart_tx_param;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] d   = '0;
   logic [4:0] valid = '0;
   logic [4:0] ready;
   logic [4:0] busy;
   logic [4:0] done;
   logic [4:0] txl;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // 0: 8N1  1: 7E1  2: 7O1  3: 8N2  (all 10 clocks/bit)  4: defaults
   uart_tx_param #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000),
      .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_a (
      .clk(clk), .rst(rst), .tx_data(d), .tx_valid(valid[0]),
      .tx_ready(ready[0]), .tx_busy(busy[0]), .tx_done(done[0]),
      .tx(txl[0]));

   uart_tx_param #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000),
      .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1)) u_b (
      .clk(clk), .rst(rst), .tx_data(d[6:0]), .tx_valid(valid[1]),
      .tx_ready(ready[1]), .tx_busy(busy[1]), .tx_done(done[1]),
      .tx(txl[1]));

   uart_tx_param #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000),
      .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1)) u_c (
      .clk(clk), .rst(rst), .tx_data(d[6:0]), .tx_valid(valid[2]),
      .tx_ready(ready[2]), .tx_busy(busy[2]), .tx_done(done[2]),
      .tx(txl[2]));

   uart_tx_param #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000),
      .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_d (
      .clk(clk), .rst(rst), .tx_data(d), .tx_valid(valid[3]),
      .tx_ready(ready[3]), .tx_busy(busy[3]), .tx_done(done[3]),
      .tx(txl[3]));

   uart_tx_param u_e (
      .clk(clk), .rst(rst), .tx_data(d), .tx_valid(valid[4]),
      .tx_ready(ready[4]), .tx_busy(busy[4]), .tx_done(done[4]),
      .tx(txl[4]));

   typedef struct {
      string      name;
      int         sel;
      logic [7:0] data;
      int         nbits;
      int         pbit;
      int         stops;
      int         cpb;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   // Entered at the negedge of cycle 1 (first start-bit cycle).
   // Leaves at the negedge of the tx_done cycle.
   task automatic check_frame(input int sel, input logic [7:0] data,
                              input int nbits, input int pbit,
                              input int stops, input int cpb,
                              input string name);
      logic bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < nbits; i++) bits.push_back(data[i]);
      if (pbit >= 0) bits.push_back(pbit[0]);
      for (int i = 0; i < stops; i++) bits.push_back(1'b1);
      foreach (bits[b]) begin
         int good = 0;
         for (int c = 0; c < cpb; c++) begin
            if (txl[sel] == bits[b] && !ready[sel] && busy[sel] &&
                !done[sel])
               good++;
            @(negedge clk);
         end
         chk($sformatf("%s bit%0d cycles", name, b), good, cpb);
      end
      chk($sformatf("%s done", name), int'(done[sel]), 1);
      chk($sformatf("%s ready", name), int'(ready[sel]), 1);
      chk($sformatf("%s busy", name), int'(busy[sel]), 0);
      chk($sformatf("%s tx idle", name), int'(txl[sel]), 1);
   endtask

   task automatic send(input vec_t v);
      d = v.data;
      valid[v.sel] = 1'b1;
      @(negedge clk);
      valid[v.sel] = 1'b0;
      check_frame(v.sel, v.data, v.nbits, v.pbit, v.stops, v.cpb,
                  v.name);
      @(negedge clk);
      chk({v.name, " done pulse ends"}, int'(done[v.sel]), 0);
   endtask

   task automatic idle_watch(input int sel, input int n,
                             input string name);
      int good = 0;
      for (int i = 0; i < n; i++) begin
         if (txl[sel] && ready[sel] && !busy[sel] && !done[sel])
            good++;
         @(negedge clk);
      end
      chk(name, good, n);
   endtask

   initial begin
      vecs.push_back('{"8N1 55", 0, 8'h55, 8, -1, 1, 10});
      vecs.push_back('{"8N1 FF", 0, 8'hFF, 8, -1, 1, 10});
      vecs.push_back('{"8N1 01", 0, 8'h01, 8, -1, 1, 10});
      vecs.push_back('{"7E1 03", 1, 8'h03, 7, 0, 1, 10});
      vecs.push_back('{"7O1 03", 2, 8'h03, 7, 1, 1, 10});
      vecs.push_back('{"7E1 7F", 1, 8'h7F, 7, 1, 1, 10});
      vecs.push_back('{"7O1 55", 2, 8'h55, 7, 1, 1, 10});
      vecs.push_back('{"7E1 54", 1, 8'h54, 7, 1, 1, 10});
      vecs.push_back('{"8N2 A5", 3, 8'hA5, 8, -1, 2, 10});
      vecs.push_back('{"dflt 00", 4, 8'h00, 8, -1, 1, 2083});

      repeat (3) @(negedge clk);
      chk("reset tx", int'(txl), 31);
      chk("reset ready", int'(ready), 31);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      foreach (vecs[i]) begin
         send(vecs[i]);
         repeat (3) @(negedge clk);
      end

      // Back-to-back on 8N2 with tx_valid held.
      d = 8'hA5;
      valid[3] = 1'b1;
      @(negedge clk);
      d = 8'h3C;
      check_frame(3, 8'hA5, 8, -1, 2, 10, "b2b first");
      @(negedge clk);
      valid[3] = 1'b0;
      check_frame(3, 8'h3C, 8, -1, 2, 10, "b2b second");
      @(negedge clk);
      idle_watch(3, 20, "b2b idle after");

      // Reset in the middle of a data bit.
      d = 8'h55;
      valid[0] = 1'b1;
      @(negedge clk);
      valid[0] = 1'b0;
      repeat (44) @(negedge clk);
      chk("rst pre tx", int'(txl[0]), 0);
      #2 rst = 1'b1;
      #1;
      chk("rst tx async", int'(txl[0]), 1);
      chk("rst ready async", int'(ready[0]), 1);
      chk("rst busy async", int'(busy[0]), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle_watch(0, 120, "rst no done");
      send(vecs[0]);

      // Input noise during a frame is ignored.
      d = 8'h55;
      valid[0] = 1'b1;
      @(negedge clk);
      valid[0] = 1'b0;
      fork
         check_frame(0, 8'h55, 8, -1, 1, 10, "noise frame");
         begin
            repeat (19) @(negedge clk);
            for (int i = 0; i < 41; i++) begin
               valid[0] = (i % 2 == 0);
               d = 8'($urandom);
               @(negedge clk);
            end
            valid[0] = 1'b0;
         end
      join
      @(negedge clk);
      idle_watch(0, 30, "noise no second frame");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter, the successor to the fixed 7-bit sender. It serialises one word per valid/ready handshake as start bit, DATA_BITS data bits LSB-first, optional parity and 1 or 2 stop bits. The baud divider is derived from clock frequency and baud rate. It sits between any byte-producing core and the FPGA TX pin, and drives idle-high when not sending.

Parameters:
CLK_FREQ_HZ, 20_000_000, system clock frequency (50 ns period).
BAUD_RATE, 9600, line rate in bits/s.
DATA_BITS, 8, data bits per frame; legal 5..9.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, legal 1 or 2.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  reset, asynchronous, active-high.
tx_data  input  DATA_BITS  word to send; sampled only at acceptance.
tx_valid  input  1  producer has a word.
tx_ready  output  1  block can accept; high only in IDLE.
tx_busy  output  1  frame in progress (= ~tx_ready).
tx_done  output  1  one-cycle pulse after the final stop bit completes.
tx  output  1  serial line; idle 1.

Behaviour:
- Clock and reset: one clock `clk`; reset is asynchronous and active-high.
- Divider: CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD_RATE/2) / BAUD_RATE, rounded. Default is 2083. Elaboration fails if CLKS_PER_BIT < 2, DATA_BITS is outside 5..9, PARITY_MODE > 2, or STOP_BITS is not 1 or 2.
- Reset values: tx = 1, tx_ready = 1, tx_busy = 0, tx_done = 0. State = IDLE; bit and baud counters = 0. The shift register is cleared.
- Reset mid-frame: tx returns to 1 immediately (async). The frame is abandoned and no tx_done is produced.
- Acceptance: occurs at the posedge where tx_valid & tx_ready & ~rst.
  - tx_data is latched into the shift register.
  - Parity is computed from the latched word: even = XOR of the data bits; odd = its inverse.
  - tx_valid while busy is ignored, with no queuing.
  - Changes to tx_data after acceptance have no effect.
- Latency: the start bit appears on tx in the cycle after acceptance. Every bit is held exactly CLKS_PER_BIT cycles.
- FSM states and transitions:
  - IDLE: tx = 1. Goes to START on acceptance.
  - START: tx = 0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx = shift[0], shifting right once per bit. After DATA_BITS bits, goes to PARITY if PARITY_MODE != 0, otherwise STOP.
  - PARITY: tx = parity bit for one bit time, then STOP.
  - STOP: tx = 1 for STOP_BITS × CLKS_PER_BIT cycles, then IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps on a bit boundary. It is reset to 0 on acceptance and on every state change. Its width is $clog2(CLKS_PER_BIT).
- Bit counter: counts 0..DATA_BITS-1 in DATA. It also counts the stop bits in STOP.
- Frame length: F = 1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS bits.
  - If acceptance is at cycle 0, the start bit occupies cycles 1..CLKS_PER_BIT.
  - The last stop bit ends at cycle F × CLKS_PER_BIT.
  - tx_done = 1 and tx_ready = 1 in cycle F × CLKS_PER_BIT + 1.
- Back-to-back frames: if tx_valid is high in the tx_done cycle, the next word is accepted that cycle. Its start bit begins the following cycle, so the idle gap is exactly 1 cycle.
- tx_done and acceptance may coincide. Both take effect and the next frame starts normally.

Test Plan:
All tests use CLK_FREQ_HZ = 1_000_000 and BAUD_RATE = 100_000, so CLKS_PER_BIT = 10. Acceptance is at cycle 0.
1. DATA_BITS=8, PARITY_MODE=0, STOP_BITS=1; send 0x55 -> tx = 0,1,0,1,0,1,0,1,0 then stop 1, each held 10 cycles over cycles 1..100; tx_done and tx_ready high at cycle 101 only.
2. DATA_BITS=7, PARITY_MODE=1; send 0x03 -> parity bit 0 during cycles 81..90, stop 91..100. With PARITY_MODE=2 and the same word -> parity bit 1.
3. DATA_BITS=8, STOP_BITS=2, tx_valid held; send 0xA5 then 0x3C -> first frame occupies cycles 1..110; tx_done at 111 with 0x3C accepted the same cycle; second start bit begins at cycle 112.
4. Reset asserted at cycle 45 (inside a data bit) -> tx = 1 in the same cycle. tx_ready = 1 and tx_busy = 0 from then on. No tx_done is seen. The next send after release produces a clean frame.
5. Toggle tx_data and pulse tx_valid during cycles 20..60 of a 0x55 frame -> waveform is identical to test 1 and no second frame is started.
6. Default parameters (CLKS_PER_BIT = 2083); send 0x00, 8N1 -> tx low for 9 × 2083 = 18747 cycles, then high for 2083 cycles.
